pll_lock_reset_seq: RTL and testbench



---
 rtl/pll_lock_reset_seq.sv | 176 +++++++++++++++++
 tb/tb_pll_lock_reset_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_reset_seq.sv
// pll_lock_reset_seq: holds the fabric in reset until the PLL lock indicator
// has been stable for LOCK_STABLE_CYCLES and then for a further
// RESET_HOLD_CYCLES. Any loss of lock drops straight back to waiting for lock;
// a software reset request while running re-runs only the hold window.
// Optional feature macro: PLL_LOCK_LOSS_CNT_EN (saturating lock-loss counter).
module pll_lock_reset_seq #(
  parameter int LOCK_SYNC_STAGES   = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int LOSS_CNT_W         = 8
) (
  input  logic                  GL0,
  input  logic                  RESET,
  input  logic                  LOCK,
  input  logic                  EXT_RST_REQ,
  output logic                  SYS_RESET,
  output logic                  SYS_READY,
  output logic                  LOCK_STABLE,
  output logic [LOSS_CNT_W-1:0] LOSS_CNT
);

  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                           LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LS_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RH_LAST  = CNT_W'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    DEBOUNCE  = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  logic [LOCK_SYNC_STAGES-1:0] sync_r;
  logic                        lock_s;
  state_t                      state_r;
  state_t                      state_nxt_s;
  logic [CNT_W-1:0]            cnt_r;
  logic [CNT_W-1:0]            cnt_nxt_s;
  logic                        sys_reset_nxt_s;
  logic                        sys_ready_nxt_s;
  logic                        lock_stable_nxt_s;
  logic                        sys_reset_r;
  logic                        sys_ready_r;
  logic                        lock_stable_r;

  // Bring the asynchronous lock indicator into the GL0 domain.
  always_ff @(posedge GL0 or posedge RESET) begin
    if (RESET) begin
      sync_r <= {LOCK_SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[LOCK_SYNC_STAGES-2:0], LOCK};
    end
  end

  assign lock_s = sync_r[LOCK_SYNC_STAGES-1];

  // State and shared qualification counter registers.
  always_ff @(posedge GL0 or posedge RESET) begin
    if (RESET) begin
      state_r <= WAIT_LOCK;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and counter update; loss of lock outranks every other event.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      WAIT_LOCK: begin
        cnt_nxt_s = CNT_ZERO;
        if (lock_s) begin
          state_nxt_s = DEBOUNCE;
        end else begin
          state_nxt_s = WAIT_LOCK;
        end
      end
      DEBOUNCE: begin
        if (!lock_s) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == LS_LAST) begin
          state_nxt_s = HOLD;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = CNT_ZERO;
        end else if (EXT_RST_REQ) begin
          cnt_nxt_s = CNT_ZERO;
        end else if (cnt_r == RH_LAST) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      RUN: begin
        cnt_nxt_s = CNT_ZERO;
        if (!lock_s) begin
          state_nxt_s = WAIT_LOCK;
        end else if (EXT_RST_REQ) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = WAIT_LOCK;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs track the state register.
  always_comb begin
    sys_reset_nxt_s   = (state_nxt_s != RUN);
    sys_ready_nxt_s   = (state_nxt_s == RUN);
    lock_stable_nxt_s = (state_nxt_s == HOLD) || (state_nxt_s == RUN);
  end

  // Registered reset/ready/stable outputs.
  always_ff @(posedge GL0 or posedge RESET) begin
    if (RESET) begin
      sys_reset_r   <= 1'b1;
      sys_ready_r   <= 1'b0;
      lock_stable_r <= 1'b0;
    end else begin
      sys_reset_r   <= sys_reset_nxt_s;
      sys_ready_r   <= sys_ready_nxt_s;
      lock_stable_r <= lock_stable_nxt_s;
    end
  end

  assign SYS_RESET   = sys_reset_r;
  assign SYS_READY   = sys_ready_r;
  assign LOCK_STABLE = lock_stable_r;

`ifdef PLL_LOCK_LOSS_CNT_EN
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX = {LOSS_CNT_W{1'b1}};
  localparam logic [LOSS_CNT_W-1:0] LOSS_ONE = LOSS_CNT_W'(1);

  logic                  loss_event_s;
  logic [LOSS_CNT_W-1:0] loss_cnt_r;

  assign loss_event_s = (state_r == RUN) && (state_nxt_s == WAIT_LOCK);

  // Saturating count of RUN -> WAIT_LOCK transitions; only RESET clears it.
  always_ff @(posedge GL0 or posedge RESET) begin
    if (RESET) begin
      loss_cnt_r <= {LOSS_CNT_W{1'b0}};
    end else if (loss_event_s && (loss_cnt_r != LOSS_MAX)) begin
      loss_cnt_r <= loss_cnt_r + LOSS_ONE;
    end else begin
      loss_cnt_r <= loss_cnt_r;
    end
  end

  assign LOSS_CNT = loss_cnt_r;
`else
  assign LOSS_CNT = {LOSS_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Self-checking bench for pll_lock_reset_seq. The reference model works on
// edge timestamps: when qualification started, when the hold window last
// (re)started, and whether the part is ready.
module tb_pll_lock_reset_seq;

  localparam int NS   = 2;
  localparam int LS   = 16;
  localparam int RH   = 4;
  localparam int LW   = 2;
  localparam int LMAX = (1 << LW) - 1;
  localparam int LAT  = NS + LS + RH + 1;   // 23
  localparam int STB  = NS + LS + 1;        // 19
`ifdef PLL_LOCK_LOSS_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic          GL0;
  logic          RESET;
  logic          LOCK;
  logic          EXT_RST_REQ;
  logic          SYS_RESET;
  logic          SYS_READY;
  logic          LOCK_STABLE;
  logic [LW-1:0] LOSS_CNT;

  pll_lock_reset_seq #(
    .LOCK_SYNC_STAGES  (NS),
    .LOCK_STABLE_CYCLES(LS),
    .RESET_HOLD_CYCLES (RH),
    .LOSS_CNT_W        (LW)
  ) dut (
    .GL0        (GL0),
    .RESET      (RESET),
    .LOCK       (LOCK),
    .EXT_RST_REQ(EXT_RST_REQ),
    .SYS_RESET  (SYS_RESET),
    .SYS_READY  (SYS_READY),
    .LOCK_STABLE(LOCK_STABLE),
    .LOSS_CNT   (LOSS_CNT)
  );

  initial GL0 = 1'b0;
  always #5 GL0 = ~GL0;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic sync_q[$];
  int   edge_no;
  int   qual_start;   // edge at which qualification began, -1 if not qualifying
  int   hold_mark;    // edge at which the current hold window started
  logic m_stable;
  logic m_ready;
  int   m_loss;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sync_q.delete();
    for (int i = 0; i < NS; i++) sync_q.push_back(1'b0);
    qual_start = -1;
    hold_mark  = 0;
    m_stable   = 1'b0;
    m_ready    = 1'b0;
    m_loss     = 0;
  endtask

  task automatic model_edge(input logic lk, input logic ex);
    logic seen;
    seen = sync_q.pop_front();
    sync_q.push_back(lk);
    edge_no++;
    if (!seen) begin
      if (m_ready && (m_loss < LMAX)) m_loss++;
      qual_start = -1;
      m_stable   = 1'b0;
      m_ready    = 1'b0;
    end else if (qual_start < 0) begin
      qual_start = edge_no;
    end else if (!m_stable) begin
      if (edge_no == qual_start + LS) begin
        m_stable  = 1'b1;
        hold_mark = edge_no;
      end
    end else if (ex) begin
      hold_mark = edge_no;
      m_ready   = 1'b0;
    end else begin
      m_ready = (edge_no >= hold_mark + RH);
    end
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".sys_reset"},   32'(SYS_RESET),   32'(!m_ready));
    chk({ctx, ".sys_ready"},   32'(SYS_READY),   32'(m_ready));
    chk({ctx, ".lock_stable"}, 32'(LOCK_STABLE), 32'(m_stable));
    chk({ctx, ".loss_cnt"},    32'(LOSS_CNT),    32'(CNT_ON ? m_loss : 0));
  endtask

  // one clock: drive at negedge, model at posedge, check 1 time unit later
  task automatic step(input logic lk, input logic ex, input logic rs);
    @(negedge GL0);
    LOCK        = lk;
    EXT_RST_REQ = ex;
    RESET       = rs;
    if (rs) model_reset();
    @(posedge GL0);
    if (!rs) model_edge(lk, ex);
    #1;
    check_outputs("step");
  endtask

  // hold LOCK high until ready; report edges to ready and to stable
  task automatic qualify(output int lat, output int stb);
    lat = 0;
    stb = 0;
    for (int i = 1; i <= 60; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if ((stb == 0) && (LOCK_STABLE === 1'b1)) stb = i;
      if (SYS_READY === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic async_reset_check(input string ctx);
    @(negedge GL0);
    #2;
    RESET = 1'b1;
    model_reset();
    #1;
    chk({ctx, ".async_sys_reset"},   32'(SYS_RESET),   32'd1);
    chk({ctx, ".async_sys_ready"},   32'(SYS_READY),   32'd0);
    chk({ctx, ".async_lock_stable"}, 32'(LOCK_STABLE), 32'd0);
    chk({ctx, ".async_loss_cnt"},    32'(LOSS_CNT),    32'd0);
  endtask

  initial begin
    int lat;
    int stb;
    int n;
    int exp5[5];

    edge_no     = 0;
    RESET       = 1'b1;
    LOCK        = 1'b0;
    EXT_RST_REQ = 1'b0;
    model_reset();

    // reset state held with LOCK low
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
    chk("rst_sys_reset", 32'(SYS_RESET), 32'd1);
    chk("rst_sys_ready", 32'(SYS_READY), 32'd0);

    // power-up qualification latency
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    qualify(lat, stb);
    chk("powerup_latency", 32'(lat), 32'(LAT));
    chk("powerup_stable",  32'(stb), 32'(STB));

    // LOCK glitch at debounce count 10 restarts qualification
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    chk("glitch_in_reset", 32'(SYS_RESET), 32'd1);
    qualify(lat, stb);
    chk("glitch_latency", 32'(lat), 32'(LAT));

    // software reset request in RUN: exactly RH cycles of reset
    step(1'b1, 1'b1, 1'b0);
    n = (SYS_RESET === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      if (SYS_RESET !== 1'b1) break;
      step(1'b1, 1'b0, 1'b0);
      if (SYS_RESET === 1'b1) n++;
    end
    chk("ext_rst_cycles", 32'(n), 32'(RH));
    chk("ext_rst_loss",   32'(LOSS_CNT), 32'd0);

    // request arriving on the same edge lock_s falls: lock loss wins
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("simul_sys_reset", 32'(SYS_RESET), 32'd1);
    chk("simul_loss",      32'(LOSS_CNT),  32'(CNT_ON));

    // five lock losses from RUN: saturating count
    for (int k = 0; k < 5; k++) exp5[k] = CNT_ON ? ((k + 1 > LMAX) ? LMAX : k + 1) : 0;
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      qualify(lat, stb);
      chk("loss_seq_latency", 32'(lat), 32'(LAT));
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
      chk("loss_seq_cnt", 32'(LOSS_CNT), 32'(exp5[k]));
    end

    // RESET pulsed during HOLD
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < STB + 1; i++) step(1'b1, 1'b0, 1'b0);
    chk("hold_before_rst", 32'(LOCK_STABLE), 32'd1);
    async_reset_check("hold");
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    qualify(lat, stb);
    chk("after_rst_latency", 32'(lat), 32'(LAT));

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
